// File: rtl/control_unit_legv8_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_legv8_if
//  Description : Bundles the signals exchanged between the LEGv8 control unit,
//                the instruction memory and the datapath.
//                master : control unit (drives pc / ControlWord / constant /
//                         halted / illegal, consumes instruction / status)
//                slave  : memory + datapath side (the opposite directions)
//  Signals     : instruction[31:0]  fetched word for address pc
//                status[3:0]        datapath flags {V, C, N, Z}
//                pc[63:0]           byte address of the current instruction
//                ControlWord[24:0]  {SA, SB, DA, RegWrite, MemWrite, FS,
//                                    Bsel, EN_Mem, EN_ALU}
//                constant[63:0]     immediate for the datapath B mux
//                halted             processor is in HALT
//                illegal            sticky undecoded-opcode flag
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_unit_legv8_if;
  logic [31:0] instruction;
  logic [3:0]  status;
  logic [63:0] pc;
  logic [24:0] ControlWord;
  logic [63:0] constant;
  logic        halted;
  logic        illegal;

  modport master (
    input  instruction, status,
    output pc, ControlWord, constant, halted, illegal
  );

  modport slave (
    output instruction, status,
    input  pc, ControlWord, constant, halted, illegal
  );
endinterface
`default_nettype wire

// File: rtl/control_unit_legv8.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_legv8
//  Description : Multi-cycle control unit for the LEGv8 datapath. Owns the
//                program counter and the instruction register, fetches one
//                32-bit word per instruction, decodes a fixed subset and
//                issues the 25-bit ControlWord plus the 64-bit constant.
//                States: FETCH -> EXEC -> (LOAD) -> FETCH, or HALT.
//  Ports       : clock      single rising-edge clock
//                reset      asynchronous, active-low reset
//                bus        control_unit_legv8_if.master
//                  instruction (in)  word at address pc, combinational
//                  status      (in)  {V, C, N, Z}; only Z is consumed
//                  pc          (out) current instruction address
//                  ControlWord (out) datapath control word
//                  constant    (out) B-mux immediate
//                  halted      (out) high in HALT
//                  illegal     (out) sticky, set on undecoded opcode
//  Parameters  : RESET_PC   PC value loaded on reset
//  Revision    : 1.0 - initial release
// ============================================================================
module control_unit_legv8 #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic                 clock,
  input  logic                 reset,
  control_unit_legv8_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_LOAD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // Opcode fields, matched against the top bits of the instruction register
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [31:0] INSN_HLT = 32'hD440_0000;

  localparam logic [4:0]  FS_AND  = 5'b00000;
  localparam logic [4:0]  FS_ORR  = 5'b00100;
  localparam logic [4:0]  FS_ADD  = 5'b01000;
  localparam logic [4:0]  FS_SUB  = 5'b01001;

  localparam logic [4:0]  REG_ZR  = 5'd31;
  localparam logic [63:0] PC_STEP = 64'd4;

  // --------------------------------------------------------------------------
  // Architectural state
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  // --------------------------------------------------------------------------
  // Instruction field extraction from IR
  // --------------------------------------------------------------------------
  logic [4:0]  rd_f;       // Rd for R/I formats, Rt for D/CB formats
  logic [4:0]  rn_f;
  logic [4:0]  rm_f;
  logic [63:0] imm12_zx;
  logic [63:0] imm9_sx;
  logic [63:0] br_off;     // CB-format displacement, already scaled to bytes
  logic [63:0] b_off;      // B-format displacement, already scaled to bytes

  assign rd_f     = ir_q[4:0];
  assign rn_f     = ir_q[9:5];
  assign rm_f     = ir_q[20:16];
  assign imm12_zx = {52'd0, ir_q[21:10]};
  assign imm9_sx  = {{55{ir_q[20]}}, ir_q[20:12]};
  assign br_off   = {{43{ir_q[23]}}, ir_q[23:5], 2'b00};
  assign b_off    = {{36{ir_q[25]}}, ir_q[25:0], 2'b00};

  // --------------------------------------------------------------------------
  // Instruction class decode
  // --------------------------------------------------------------------------
  logic       dec_r;
  logic       dec_i;
  logic       dec_ldur;
  logic       dec_cbz;
  logic       dec_cbnz;
  logic       dec_b;
  logic       dec_hlt;
  logic       wr_ok;
  logic [4:0] fs_r;
  logic [4:0] fs_i;

  assign dec_r    = (ir_q[31:21] == OP_ADD) || (ir_q[31:21] == OP_SUB) ||
                    (ir_q[31:21] == OP_AND) || (ir_q[31:21] == OP_ORR);
  assign dec_i    = (ir_q[31:22] == OP_ADDI) || (ir_q[31:22] == OP_SUBI);
  assign dec_ldur = (ir_q[31:21] == OP_LDUR);
  assign dec_cbz  = (ir_q[31:24] == OP_CBZ);
  assign dec_cbnz = (ir_q[31:24] == OP_CBNZ);
  assign dec_b    = (ir_q[31:26] == OP_B);
  assign dec_hlt  = (ir_q == INSN_HLT);

  // X31 is the zero register: writes to it are suppressed at the source
  assign wr_ok    = (rd_f != REG_ZR);

  // SUBI differs from ADDI only in bit 30
  assign fs_i     = ir_q[30] ? FS_SUB : FS_ADD;

  always_comb begin
    case (ir_q[31:21])
      OP_SUB:  fs_r = FS_SUB;
      OP_AND:  fs_r = FS_AND;
      OP_ORR:  fs_r = FS_ORR;
      default: fs_r = FS_ADD;
    endcase
  end

  // --------------------------------------------------------------------------
  // Moore outputs: a function of state and IR only, so an asserted reset
  // zeroes the control word in the same cycle.
  // --------------------------------------------------------------------------
  logic [4:0]  sa_w, sb_w, da_w, fs_w;
  logic        regwrite_w, bsel_w, en_mem_w, en_alu_w;
  logic [63:0] const_w;

  always_comb begin
    sa_w       = 5'd0;
    sb_w       = 5'd0;
    da_w       = 5'd0;
    fs_w       = 5'd0;
    regwrite_w = 1'b0;
    bsel_w     = 1'b0;
    en_mem_w   = 1'b0;
    en_alu_w   = 1'b0;
    const_w    = 64'd0;
    case (state_q)
      S_EXEC: begin
        if (dec_r) begin
          sa_w       = rn_f;
          sb_w       = rm_f;
          da_w       = rd_f;
          fs_w       = fs_r;
          regwrite_w = wr_ok;
          en_alu_w   = 1'b1;
        end else if (dec_i) begin
          sa_w       = rn_f;
          da_w       = rd_f;
          fs_w       = fs_i;
          bsel_w     = 1'b1;
          regwrite_w = wr_ok;
          en_alu_w   = 1'b1;
          const_w    = imm12_zx;
        end else if (dec_ldur) begin
          // Address phase: ALU forms Rn + imm9 for the registered RAM read
          sa_w       = rn_f;
          fs_w       = FS_ADD;
          bsel_w     = 1'b1;
          const_w    = imm9_sx;
        end else if (dec_cbz || dec_cbnz) begin
          // Rt OR 0 passes Rt through the ALU so Z reflects Rt == 0
          sa_w       = rd_f;
          fs_w       = FS_ORR;
          bsel_w     = 1'b1;
        end
      end
      S_LOAD: begin
        // Address fields are repeated so the RAM address stays stable while
        // the read data is steered into Rt.
        sa_w       = rn_f;
        fs_w       = FS_ADD;
        bsel_w     = 1'b1;
        const_w    = imm9_sx;
        da_w       = rd_f;
        en_mem_w   = 1'b1;
        regwrite_w = wr_ok;
      end
      default: ;
    endcase
  end

  assign bus.ControlWord = {sa_w, sb_w, da_w, regwrite_w, 1'b0, fs_w,
                            bsel_w, en_mem_w, en_alu_w};
  assign bus.constant    = const_w;
  assign bus.pc          = pc_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.illegal     = illegal_q;

  // Only Z takes part in branch resolution
  logic status_z;
  logic unused_status;
  assign status_z      = bus.status[0];
  assign unused_status = ^bus.status[3:1];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = bus.instruction;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (dec_r || dec_i) begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_FETCH;
        end else if (dec_ldur) begin
          // PC advances only once the load data has been written
          state_d = S_LOAD;
        end else if (dec_cbz || dec_cbnz) begin
          if (dec_cbz ? status_z : !status_z) begin
            pc_d = pc_q + br_off;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
          state_d = S_FETCH;
        end else if (dec_b) begin
          pc_d    = pc_q + b_off;
          state_d = S_FETCH;
        end else if (dec_hlt) begin
          state_d = S_HALT;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_LOAD: begin
        pc_d    = pc_q + PC_STEP;
        state_d = S_FETCH;
      end
      default: ;  // HALT holds everything until reset
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_unit_legv8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit_legv8
//  Description : Scoreboard bench for control_unit_legv8. A per-instruction
//                reference model expands each issued instruction into the
//                sequence of per-cycle outputs it must produce; a monitor
//                compares the DUT against that queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_control_unit_legv8;

  localparam logic [63:0] RESET_PC = 64'd0;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  localparam int K_NORMAL  = 0;
  localparam int K_LOAD    = 1;
  localparam int K_HALT    = 2;
  localparam int K_ILLEGAL = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  control_unit_legv8_if bus();

  control_unit_legv8 #(.RESET_PC(RESET_PC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [24:0] cw;
    logic [63:0] k;
    logic        h;
    logic        il;
  } exp_t;

  exp_t sb_q[$];
  event smp;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state: architectural view only
  logic [63:0] m_pc        = RESET_PC;
  logic        m_il        = 1'b0;
  logic        m_halted    = 1'b0;
  logic        rel_pending = 1'b0;

  function automatic logic [24:0] mk_cw(input logic [4:0] sa, input logic [4:0] sb,
                                        input logic [4:0] da, input logic rw,
                                        input logic [4:0] fs, input logic bsel,
                                        input logic enm, input logic ena);
    return {sa, sb, da, rw, 1'b0, fs, bsel, enm, ena};
  endfunction

  // Per-instruction behaviour: control word in EXEC, in LOAD, immediate,
  // and the PC once the instruction retires.
  function automatic void model(input logic [31:0] ir, input logic [63:0] pc, input logic z,
                                output int kind, output logic [24:0] cw_e,
                                output logic [63:0] k, output logic [24:0] cw_l,
                                output logic [63:0] npc);
    logic [4:0] rd, rn, rm;
    logic       wr;
    logic signed [63:0] off;
    rd   = ir[4:0];
    rn   = ir[9:5];
    rm   = ir[20:16];
    wr   = (rd != 5'd31);
    kind = K_NORMAL;
    cw_e = '0;
    cw_l = '0;
    k    = '0;
    npc  = pc + 64'd4;
    if (ir == 32'hD440_0000) begin
      kind = K_HALT;
      npc  = pc;
    end else if (ir[31:21] == 11'b10001011000) begin
      cw_e = mk_cw(rn, rm, rd, wr, FS_ADD, 1'b0, 1'b0, 1'b1);
    end else if (ir[31:21] == 11'b11001011000) begin
      cw_e = mk_cw(rn, rm, rd, wr, FS_SUB, 1'b0, 1'b0, 1'b1);
    end else if (ir[31:21] == 11'b10001010000) begin
      cw_e = mk_cw(rn, rm, rd, wr, FS_AND, 1'b0, 1'b0, 1'b1);
    end else if (ir[31:21] == 11'b10101010000) begin
      cw_e = mk_cw(rn, rm, rd, wr, FS_ORR, 1'b0, 1'b0, 1'b1);
    end else if (ir[31:22] == 10'b1001000100) begin
      cw_e = mk_cw(rn, 5'd0, rd, wr, FS_ADD, 1'b1, 1'b0, 1'b1);
      k    = 64'(ir[21:10]);
    end else if (ir[31:22] == 10'b1101000100) begin
      cw_e = mk_cw(rn, 5'd0, rd, wr, FS_SUB, 1'b1, 1'b0, 1'b1);
      k    = 64'(ir[21:10]);
    end else if (ir[31:21] == 11'b11111000010) begin
      kind = K_LOAD;
      k    = 64'($signed(ir[20:12]));
      cw_e = mk_cw(rn, 5'd0, 5'd0, 1'b0, FS_ADD, 1'b1, 1'b0, 1'b0);
      cw_l = mk_cw(rn, 5'd0, rd, wr, FS_ADD, 1'b1, 1'b1, 1'b0);
    end else if (ir[31:24] == 8'hB4 || ir[31:24] == 8'hB5) begin
      cw_e = mk_cw(rd, 5'd0, 5'd0, 1'b0, FS_ORR, 1'b1, 1'b0, 1'b0);
      off  = 64'($signed(ir[23:5]));
      if ((ir[24] == 1'b0) ? z : !z) npc = pc + 64'(off * 4);
    end else if (ir[31:26] == 6'b000101) begin
      off  = 64'($signed(ir[25:0]));
      npc  = pc + 64'(off * 4);
    end else begin
      kind = K_ILLEGAL;
      npc  = pc;
    end
  endfunction

  task automatic sample(input logic [63:0] pc, input logic [24:0] cw, input logic [63:0] k,
                        input logic h, input logic il);
    exp_t e;
    e.pc = pc; e.cw = cw; e.k = k; e.h = h; e.il = il;
    sb_q.push_back(e);
    -> smp;
  endtask

  // Monitor: compares the DUT against the oldest expectation on every sample
  initial begin
    exp_t e;
    forever begin
      @(smp);
      #1;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_underflow @%0t: got a sample, required a queued expectation", $time);
      end else begin
        e = sb_q.pop_front();
        if (bus.pc !== e.pc || bus.ControlWord !== e.cw || bus.constant !== e.k ||
            bus.halted !== e.h || bus.illegal !== e.il) begin
          n_err++;
          $display("FAIL cycle_check @%0t: got pc=%h cw=%h const=%h halted=%b illegal=%b, required pc=%h cw=%h const=%h halted=%b illegal=%b",
                   $time, bus.pc, bus.ControlWord, bus.constant, bus.halted, bus.illegal,
                   e.pc, e.cw, e.k, e.h, e.il);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    sample(RESET_PC, '0, '0, 1'b0, 1'b0);
    m_pc        = RESET_PC;
    m_il        = 1'b0;
    m_halted    = 1'b0;
    rel_pending = 1'b1;
  endtask

  task automatic hold_halt(input int n);
    repeat (n) begin
      @(negedge clock);
      sample(m_pc, '0, '0, 1'b1, m_il);
      bus.instruction = $urandom;
      bus.status      = 4'($urandom);
    end
  endtask

  // Drives one instruction through FETCH / EXEC / (LOAD); abort_load pulls
  // reset in the middle of the LOAD cycle.
  task automatic issue(input logic [31:0] ir, input logic z, input logic abort_load);
    int          kind;
    logic [24:0] cw_e, cw_l;
    logic [63:0] k, npc;
    model(ir, m_pc, z, kind, cw_e, k, cw_l, npc);
    @(negedge clock);
    if (rel_pending) begin
      reset       = 1'b1;
      rel_pending = 1'b0;
    end
    sample(m_pc, '0, '0, 1'b0, m_il);
    bus.instruction = ir;
    bus.status      = 4'($urandom);
    @(negedge clock);
    sample(m_pc, cw_e, k, 1'b0, m_il);
    bus.instruction = $urandom;
    bus.status      = {3'($urandom), z};
    if (kind == K_LOAD) begin
      @(negedge clock);
      sample(m_pc, cw_l, k, 1'b0, m_il);
      bus.instruction = $urandom;
      bus.status      = 4'($urandom);
      if (abort_load) begin
        #3;
        reset = 1'b0;
        sample(RESET_PC, '0, '0, 1'b0, 1'b0);
        m_pc        = RESET_PC;
        m_il        = 1'b0;
        m_halted    = 1'b0;
        rel_pending = 1'b1;
        return;
      end
    end
    m_pc = npc;
    if (kind == K_ILLEGAL) m_il = 1'b1;
    m_halted = (kind == K_HALT || kind == K_ILLEGAL);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int sel;
    r   = $urandom;
    sel = $urandom_range(0, 23);
    case (sel)
      0, 1:   return {11'b10001011000, r[20:0]};
      2, 3:   return {11'b11001011000, r[20:0]};
      4:      return {11'b10001010000, r[20:0]};
      5:      return {11'b10101010000, r[20:0]};
      6, 7:   return {10'b1001000100, r[21:0]};
      8:      return {10'b1101000100, r[21:0]};
      9, 10, 11: return {11'b11111000010, r[20:0]};
      12, 13: return {8'hB4, r[23:0]};
      14, 15: return {8'hB5, r[23:0]};
      16, 17: return {6'b000101, r[25:0]};
      18:     return 32'hD440_0000;
      19:     return {11'b11111000000, r[20:0]};
      default: return {r[31:5], 5'd31} ^ {$urandom_range(0, 1) == 0 ? 32'd0 : r};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ins;
    bus.instruction = 32'd0;
    bus.status      = 4'd0;

    do_reset();
    // Directed program
    issue(32'h9100_1441, 1'b0, 1'b0);                                   // ADDI X1,X2,#5 @0
    issue(32'hCB05_0083, 1'b1, 1'b0);                                   // SUB X3,X4,X5 @4
    issue({8'hB4, 19'd3, 5'd7}, 1'b1, 1'b0);                            // CBZ taken @8 -> 20
    issue({8'hB4, 19'd3, 5'd7}, 1'b0, 1'b0);                            // CBZ not taken
    issue({8'hB5, 19'd3, 5'd7}, 1'b1, 1'b0);                            // CBNZ not taken
    issue({8'hB5, 19'd3, 5'd7}, 1'b0, 1'b0);                            // CBNZ taken
    issue({11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd31}, 1'b0, 1'b0);      // ADD X31 -> no write
    issue({11'b10001010000, 5'd6, 6'd0, 5'd7, 5'd8}, 1'b0, 1'b0);       // AND
    issue({11'b10101010000, 5'd9, 6'd0, 5'd10, 5'd11}, 1'b1, 1'b0);     // ORR
    issue({10'b1101000100, 12'hFFF, 5'd3, 5'd4}, 1'b0, 1'b0);           // SUBI max imm12
    issue({6'b000101, 26'h3FF_FFFE}, 1'b0, 1'b0);                       // B -2
    issue(32'hF85F_8149, 1'b0, 1'b0);                                   // LDUR X9,[X10,#-8]
    issue({11'b11111000010, 9'd5, 2'b00, 5'd1, 5'd31}, 1'b0, 1'b0);     // LDUR to XZR
    issue(32'hD440_0000, 1'b0, 1'b0);                                   // HLT
    hold_halt(12);
    do_reset();
    issue(32'h9100_1441, 1'b0, 1'b0);
    issue(32'hF85F_8149, 1'b0, 1'b1);                                   // reset mid-LOAD
    issue(32'h9100_1441, 1'b0, 1'b0);
    issue(32'hF800_0000, 1'b0, 1'b0);                                   // STUR -> illegal
    hold_halt(4);
    do_reset();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      ins = rand_instr();
      issue(ins, 1'($urandom), ($urandom_range(0, 7) == 0));
      if (m_halted) begin
        hold_halt($urandom_range(1, 4));
        do_reset();
      end
    end

    if (rel_pending) begin
      @(negedge clock);
      reset = 1'b1;
    end
    @(negedge clock);
    #3;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expectations, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_unit_legv8.md
# control_unit_legv8

Multi-cycle control unit that drives the LEGv8 datapath. It fetches 32-bit instructions, decodes a fixed subset, and issues the 25-bit `ControlWord` and 64-bit `constant` that the datapath consumes. It takes the ALU `status` back from the datapath for conditional branches. It owns the program counter and the instruction register, and sits between instruction memory and the datapath.

## Interface
Parameters:
- `RESET_PC`, default 64'd0: PC value loaded on reset.

Ports:
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `instruction` input 32: instruction-memory read data for address `pc`; combinational, valid in the same cycle.
- `status` input 4: datapath ALU flags {V, C, N, Z}; Z = `status[0]`, combinational from the current control word.
- `pc` output 64: byte address of the current instruction.
- `ControlWord` output 25: {SA[24:20], SB[19:15], DA[14:10], RegWrite[9], MemWrite[8], FS[7:3], Bsel[2], EN_Mem[1], EN_ALU[0]}.
- `constant` output 64: immediate for the datapath B mux.
- `halted` output 1: high in HALT.
- `illegal` output 1: sticky; set when HALT is entered on an undecoded opcode.

## Operation
- FS codes: AND 00000, ORR 00100, ADD 01000, SUB 01001.
- States: FETCH, EXEC, LOAD, HALT.
- FETCH: IR <= `instruction`. `ControlWord` = 0 and `constant` = 0. Next state is EXEC.
- EXEC: decode IR.
  - ADD (10001011000), SUB (11001011000), AND (10001010000), ORR (10101010000):
    - SA = Rn, SB = Rm, DA = Rd, Bsel = 0.
    - RegWrite = 1, EN_ALU = 1.
    - PC += 4. Next state is FETCH.
  - ADDI (1001000100), SUBI (1101000100):
    - SA = Rn, DA = Rd, Bsel = 1, RegWrite = 1, EN_ALU = 1.
    - `constant` = zero-extended imm12.
    - PC += 4. Next state is FETCH.
  - LDUR (11111000010):
    - SA = Rn, Bsel = 1, FS = ADD.
    - `constant` = sign-extended imm9.
    - RegWrite = 0, EN_Mem = 0, EN_ALU = 0.
    - Next state is LOAD.
  - CBZ (10110100), CBNZ (10110101):
    - SA = Rt, Bsel = 1, `constant` = 0, FS = ORR, no write, no enables.
    - Taken when Z == 1 for CBZ, or Z == 0 for CBNZ.
    - Taken: PC += sext(imm19) << 2. Not taken: PC += 4.
    - Next state is FETCH.
  - B (000101): PC += sext(imm26) << 2, control word 0. Next state is FETCH.
  - HLT (32'hD4400000): next state is HALT, PC unchanged.
  - Any other encoding, including STUR (not supported on this datapath): next state is HALT, `illegal` <= 1, PC unchanged.
- LOAD: repeat the EXEC address fields (SA, Bsel, FS, `constant`) so the RAM address is held, and add DA = Rt, EN_Mem = 1, RegWrite = 1. PC += 4. Next state is FETCH.
- Rd/Rt = 31 as a destination: RegWrite is forced to 0.
- HALT: `ControlWord` = 0, all state held until reset.
- EN_Mem and EN_ALU are never both 1.
- PC arithmetic is 64-bit two's complement, modulo 2^64; no overflow detection.

## Timing
- Reset (asynchronous, low), effective immediately:
  - state = FETCH, PC = `RESET_PC`, IR = 0.
  - `ControlWord` = 0, `constant` = 0, `halted` = 0, `illegal` = 0.
- Reset during any state, including mid-LOAD: register write and memory enable drop immediately; the instruction is abandoned.
- Outputs are combinational from state and IR (Moore).
- `status` is sampled at the EXEC clock edge only.
- Latency per instruction:
  - ALU and immediate instructions: 2 cycles (FETCH, EXEC); the register write commits at the end of EXEC.
  - Branches: 2 cycles; PC updates at the end of EXEC.
  - LDUR: 3 cycles. RAM read is registered with 1-cycle latency; data is written at the end of LOAD.
- First FETCH after reset release happens on the first rising edge with `reset` high.

## Test plan
- ADDI X1, X2, #5 (32'h91001441) at PC 0: in EXEC, SA = 2, DA = 1, FS = 01000, Bsel = 1, RegWrite = 1, EN_ALU = 1, `constant` = 5; `pc` = 4 after 2 clocks.
- SUB X3, X4, X5 (32'hCB050083): in EXEC, SA = 4, SB = 5, DA = 3, FS = 01001, Bsel = 0, RegWrite = 1, EN_ALU = 1; ADD Rd = 31 gives RegWrite = 0.
- CBZ X7, #3 at PC 8:
  - Z = 1 gives `pc` = 20.
  - Z = 0 gives `pc` = 12.
  - CBNZ gives the inverse.
  - B with imm26 = -2 at PC 16 gives `pc` = 8.
- LDUR X9, [X10, #-8] (32'hF85F8149):
  - EXEC: SA = 10, `constant` = 64'hFFFF_FFFF_FFFF_FFF8, EN_Mem = 0.
  - LOAD: DA = 9, EN_Mem = 1, RegWrite = 1.
  - `pc` advances after 3 clocks.
- HLT gives `halted` = 1, `illegal` = 0, `pc` frozen for 10+ cycles. STUR (32'hF8000000) gives `halted` = 1, `illegal` = 1.
- Assert `reset` low mid-LOAD: `ControlWord` = 0 in the same cycle, `pc` = `RESET_PC`, `illegal` cleared; execution resumes from FETCH after release.
